// File: rtl/nor_logic_pipe_pkg.sv
// Shared definitions for the NOR logic pipeline: operation codes and select width.
package nor_logic_pkg;

  localparam int SEL_W    = 3;
  localparam int OP_COUNT = 8;

  typedef logic [SEL_W-1:0] op_sel_t;

  localparam op_sel_t OP_NOT    = 3'd0;
  localparam op_sel_t OP_NOR    = 3'd1;
  localparam op_sel_t OP_AND    = 3'd2;
  localparam op_sel_t OP_OR     = 3'd3;
  localparam op_sel_t OP_XOR    = 3'd4;
  localparam op_sel_t OP_XNOR   = 3'd5;
  localparam op_sel_t OP_NAND   = 3'd6;
  localparam op_sel_t OP_PASS_B = 3'd7;

endpackage

// File: rtl/nor_logic_pipe_if.sv
// Operand/result handshake bundle for nor_logic_pipe.
// NOR_LOGIC_PIPE_FLAGS_EN adds the registered zero/parity result flags.
interface nor_logic_pipe_if
  import nor_logic_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] sel;
  logic             acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
`ifdef NOR_LOGIC_PIPE_FLAGS_EN
  logic             zero;
  logic             parity;
`endif

`ifdef NOR_LOGIC_PIPE_FLAGS_EN
  modport master (
    output in_valid, a, b, sel, acc, acc_clr, out_ready,
    input  in_ready, out_valid, out, zero, parity
  );
  modport slave (
    input  in_valid, a, b, sel, acc, acc_clr, out_ready,
    output in_ready, out_valid, out, zero, parity
  );
`else
  modport master (
    output in_valid, a, b, sel, acc, acc_clr, out_ready,
    input  in_ready, out_valid, out
  );
  modport slave (
    input  in_valid, a, b, sel, acc, acc_clr, out_ready,
    output in_ready, out_valid, out
  );
`endif

endinterface

// File: rtl/nor_logic_pipe_op.sv
// Combinational bitwise function unit. Every function, the select decode and
// the AND-OR output mux are expressed purely as NOR gates.
module nor_logic_op
  import nor_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] a_n, b_n, nor_ab, or_ab, and_ab, nand_ab;
  logic [WIDTH-1:0] na_b, a_nb, xnor_ab, xor_ab, pass_b;
  logic [WIDTH-1:0] f      [OP_COUNT];
  logic [WIDTH-1:0] f_n    [OP_COUNT];
  logic [WIDTH-1:0] term   [OP_COUNT];
  logic [SEL_W-1:0] sel_n;
  logic [OP_COUNT-1:0] hot, hot_n;
  logic [WIDTH-1:0] any_term, sum_n;

  // Function generation; XNOR is the classic four-NOR arrangement.
  assign a_n     = ~(a | a);
  assign b_n     = ~(b | b);
  assign nor_ab  = ~(a | b);
  assign or_ab   = ~(nor_ab | nor_ab);
  assign and_ab  = ~(a_n | b_n);
  assign nand_ab = ~(and_ab | and_ab);
  assign na_b    = ~(a | nor_ab);
  assign a_nb    = ~(b | nor_ab);
  assign xnor_ab = ~(na_b | a_nb);
  assign xor_ab  = ~(xnor_ab | xnor_ab);
  assign pass_b  = ~(b_n | b_n);

  assign f[OP_NOT]    = a_n;
  assign f[OP_NOR]    = nor_ab;
  assign f[OP_AND]    = and_ab;
  assign f[OP_OR]     = or_ab;
  assign f[OP_XOR]    = xor_ab;
  assign f[OP_XNOR]   = xnor_ab;
  assign f[OP_NAND]   = nand_ab;
  assign f[OP_PASS_B] = pass_b;

  assign sel_n = ~(sel | sel);

  // One-hot decode: each minterm is a NOR of the complemented literals,
  // then each function is gated by its hot line (AND built as NOR of inverses).
  for (genvar k = 0; k < OP_COUNT; k++) begin : g_dec
    logic [SEL_W-1:0] lit_n;
    for (genvar i = 0; i < SEL_W; i++) begin : g_lit
      if (((k >> i) & 1) == 1) begin : g_one
        assign lit_n[i] = sel_n[i];
      end else begin : g_zero
        assign lit_n[i] = sel[i];
      end
    end
    assign hot[k]   = ~(|lit_n);
    assign hot_n[k] = ~(hot[k] | hot[k]);
    assign f_n[k]   = ~(f[k] | f[k]);
    assign term[k]  = ~({WIDTH{hot_n[k]}} | f_n[k]);
  end

  // Wide NOR across all gated terms, then a NOR inverter for the OR result.
  always_comb begin
    any_term = '0;
    for (int k = 0; k < OP_COUNT; k++) begin
      any_term = any_term | term[k];
    end
  end

  assign sum_n = ~any_term;
  assign y     = ~(sum_n | sum_n);

endmodule

// File: rtl/nor_logic_pipe.sv
// Two-stage pipelined NOR logic unit with valid/ready on both sides and an
// accumulator that can replace operand B. NOR_LOGIC_PIPE_FLAGS_EN adds
// registered zero/parity flags that travel with the result.
module nor_logic_pipe
  import nor_logic_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_ACC = '0
) (
  input logic             clk,
  input logic             rst,
  nor_logic_pipe_if.slave bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [SEL_W-1:0] s1_sel;
  logic             s1_acc;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             s2_free;
  logic             in_ready_w;
  logic             accept;
  logic             xfer;

  assign s2_free       = !out_valid_q || bus.out_ready;
  assign in_ready_w    = !s1_valid || s2_free;
  assign accept        = bus.in_valid && in_ready_w;
  assign xfer          = s1_valid && s2_free;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

  // The accumulator value is sampled at transfer time so chained ops see the
  // result of the op that moved to S2 on the previous edge.
  assign op_b = s1_acc ? acc_reg : s1_b;

  nor_logic_op #(.WIDTH(WIDTH)) u_op (
    .a   (s1_a),
    .b   (op_b),
    .sel (s1_sel),
    .y   (op_res)
  );

  // Stage 1 occupancy: fill on accept, empty when drained into S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (xfer) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 1 operand capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= bus.a;
      s1_b   <= bus.b;
      s1_sel <= bus.sel;
      s1_acc <= bus.acc;
    end
  end

  // Stage 2 result register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_q       <= op_res;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Accumulator: a clear pulse beats a coincident transfer.
  always_ff @(posedge clk) begin
    if (rst || bus.acc_clr) begin
      acc_reg <= RST_ACC;
    end else if (xfer) begin
      acc_reg <= op_res;
    end
  end

`ifdef NOR_LOGIC_PIPE_FLAGS_EN
  logic zero_q;
  logic parity_q;

  assign bus.zero   = zero_q;
  assign bus.parity = parity_q;

  // Result flags registered alongside the result itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (xfer) begin
      zero_q   <= ~(|op_res);
      parity_q <= ^op_res;
    end
  end
`endif

endmodule

// File: tb/tb_nor_logic_pipe.sv
// Bench for nor_logic_pipe: directed scenarios with literal results plus a
// randomized run, all outputs checked against an in-order reference queue.
module tb_nor_logic_pipe;
  import nor_logic_pkg::*;

  localparam int W = 8;
  localparam logic [W-1:0] RST_ACC_V = 8'h00;

  logic clk = 1'b0;
  logic rst;

  nor_logic_pipe_if #(.WIDTH(W)) bus ();

  nor_logic_pipe #(.WIDTH(W), .RST_ACC(RST_ACC_V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_m = RST_ACC_V;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out = '0;

  function automatic logic [W-1:0] ref_op(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    case (s)
      3'd0:    return ~x;
      3'd1:    return ~(x | y);
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~(x & y);
      default: return y;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model and compare, sampled on the falling edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      exp_q.delete();
      acc_m      = RST_ACC_V;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", bus.out_valid, 1'b1);
        check("stall_out_hold", bus.out, prev_out);
      end
      if (bus.acc_clr) acc_m = RST_ACC_V;
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_value", bus.out, e);
`ifdef NOR_LOGIC_PIPE_FLAGS_EN
          check("zero_flag", bus.zero, e == '0);
          check("parity_flag", bus.parity, ^e);
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = ref_op(bus.sel, bus.a, bus.acc ? acc_m : bus.b);
        acc_m = e;
        exp_q.push_back(e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = bus.out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] s, input logic xacc);
    logic took;
    bit   done;
    done = 0;
    bus.a = xa; bus.b = xb; bus.sel = s; bus.acc = xacc; bus.in_valid = 1'b1;
    #1;
    for (int c = 0; c < 50 && !done; c++) begin
      took = bus.in_ready;
      tick();
      if (took) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  logic [W-1:0] sweep_exp [8] = '{8'h0F, 8'h03, 8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'hCC};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic took_last;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0;
    bus.acc = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;

    // Reset held two cycles
    tick(); tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out", bus.out, 8'h00);
    check("rst_in_ready", bus.in_ready, 1'b1);
`ifdef NOR_LOGIC_PIPE_FLAGS_EN
    check("rst_zero", bus.zero, 1'b1);
    check("rst_parity", bus.parity, 1'b0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_valid", bus.out_valid, 1'b0);
    end

    // Op sweep back-to-back
    for (int i = 0; i < 8; i++) begin
      bus.a = 8'hF0; bus.b = 8'hCC; bus.sel = i[2:0]; bus.acc = 1'b0; bus.in_valid = 1'b1;
      tick();
      if (i >= 1) check("sweep_out", {bus.out_valid, bus.out}, {1'b1, sweep_exp[i-1]});
    end
    bus.in_valid = 1'b0;
    tick();
    check("sweep_out_last", {bus.out_valid, bus.out}, {1'b1, sweep_exp[7]});
    tick();
    check("sweep_drained", bus.out_valid, 1'b0);

    // Backpressure with three offers
    bus.out_ready = 1'b0;
    send(8'h01, 8'h02, OP_OR, 1'b0);
    send(8'h0F, 8'hF0, OP_XOR, 1'b0);
    bus.a = 8'hAA; bus.b = 8'h00; bus.sel = OP_NOT; bus.in_valid = 1'b1;
    tick(); tick();
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    check("bp_out_hold", {bus.out_valid, bus.out}, {1'b1, 8'h03});
    bus.out_ready = 1'b1;
    send(8'hAA, 8'h00, OP_NOT, 1'b0);
    check("bp_second", {bus.out_valid, bus.out}, {1'b1, 8'hFF});
    bus.in_valid = 1'b0;
    tick();
    check("bp_third", {bus.out_valid, bus.out}, {1'b1, 8'h55});
    tick(); tick();

    // Accumulator chain without bubbles
    bus.acc_clr = 1'b1; tick(); bus.acc_clr = 1'b0;
    send(8'hFF, 8'h0F, OP_AND, 1'b0);
    send(8'hF0, 8'h00, OP_OR, 1'b1);
    check("acc_and", {bus.out_valid, bus.out}, {1'b1, 8'h0F});
    send(8'h3C, 8'h00, OP_XOR, 1'b1);
    check("acc_or", {bus.out_valid, bus.out}, {1'b1, 8'hFF});
    bus.in_valid = 1'b0;
    tick();
    check("acc_xor", {bus.out_valid, bus.out}, {1'b1, 8'hC3});
    tick(); tick();

    // Clear coincident with a transfer
    send(8'hFF, 8'h0F, OP_AND, 1'b0);
    bus.in_valid = 1'b0; bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    check("clr_xfer_old_acc", {bus.out_valid, bus.out}, {1'b1, 8'h0F});
    send(8'h00, 8'h00, OP_OR, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    check("clr_wins", {bus.out_valid, bus.out}, {1'b1, 8'h00});
`ifdef NOR_LOGIC_PIPE_FLAGS_EN
    check("flag00_zero", bus.zero, 1'b1);
    check("flag00_parity", bus.parity, 1'b0);
`endif
    send(8'h00, 8'h07, OP_PASS_B, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check("pass_b_07", {bus.out_valid, bus.out}, {1'b1, 8'h07});
`ifdef NOR_LOGIC_PIPE_FLAGS_EN
    check("flag07_zero", bus.zero, 1'b0);
    check("flag07_parity", bus.parity, 1'b1);
`endif
    tick(); tick();

    // Reset with two sets in flight
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, OP_OR, 1'b0);
    send(8'h33, 8'h0F, OP_AND, 1'b0);
    bus.in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_out_valid", bus.out_valid, 1'b0);
    check("rstmid_out", bus.out, 8'h00);
    check("rstmid_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    send(8'h5A, 8'h00, OP_XOR, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    check("rstmid_acc_cleared", {bus.out_valid, bus.out}, {1'b1, 8'h5A});
    send(8'hAA, 8'h55, OP_OR, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check("rstmid_new_op", {bus.out_valid, bus.out}, {1'b1, 8'hFF});
    tick(); tick();

    // Randomized traffic with random backpressure
    took_last = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!bus.in_valid || took_last) begin
        if ($urandom_range(0, 9) < 7) begin
          bus.a = W'($urandom); bus.b = W'($urandom);
          bus.sel = 3'($urandom); bus.acc = 1'($urandom);
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.acc_clr = (exp_q.size() == 0) && ($urandom_range(0, 15) == 0);
      #1;
      took_last = bus.in_valid && bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("drain_all_emitted", exp_q.size(), 0);
    check("drain_no_valid", bus.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
